// File: rtl/axi_pkg.sv
// Shared AXI read-channel encodings and the read-slave state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BEAT  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axi_rd_slave_ram_if.sv
// AXI4 read address / read data channel bundle.
interface axi_rd_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ram_1r1w.sv
// Synchronous read-first RAM; read output clears on reset or on rd_clr.
module ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Non-blocking write above makes a same-address read return the old word.
  always_ff @(posedge clk) begin
    if (rst || rd_clr) rd_data <= '0;
    else if (rd_en)    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axi_rd_slave_ram.sv
// AXI4 read-only slave serving FIXED/INCR bursts from a preloadable word RAM.
module axi_rd_slave_ram
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  axi_rd_if.slave           s_axi,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);

  rd_state_t         state_q, state_d;
  logic              ar_hs, r_hs, rd_en;
  logic              arready_q, rvalid_q, rlast_q;
  logic [1:0]        rresp_q;
  logic [IDX_W-1:0]  addr_q;
  logic [7:0]        beats_q;
  logic              incr_q, err_q, oob_q;
  logic [ADDR_W-1:0] word_addr;
  logic              ar_oob;
  logic [IDX_W-1:0]  next_idx;
  logic              unused_bits;

  assign word_addr   = s_axi.araddr >> BYTE_SH;
  assign ar_oob      = word_addr >= ADDR_W'(DEPTH);
  assign next_idx    = (addr_q == IDX_W'(DEPTH - 1)) ? '0 : addr_q + IDX_W'(1);
  assign unused_bits = ^{s_axi.arsize, s_axi.araddr[BYTE_SH-1:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ar_hs   = 1'b0;
    r_hs    = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          ar_hs   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_d = BEAT;
      end
      BEAT: begin
        if (s_axi.rready) begin
          r_hs    = 1'b1;
          state_d = rlast_q ? IDLE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so arready never looks at arvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      beats_q   <= '0;
      incr_q    <= 1'b0;
      err_q     <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      arready_q <= (state_d == IDLE);
      rvalid_q  <= (state_d == BEAT);
      if (ar_hs) begin
        addr_q  <= word_addr[IDX_W-1:0];
        beats_q <= s_axi.arlen;
        incr_q  <= (s_axi.arburst != BURST_FIXED);
        err_q   <= ar_oob || (s_axi.arburst != BURST_FIXED && s_axi.arburst != BURST_INCR);
        oob_q   <= ar_oob;
      end
      if (rd_en) begin
        rlast_q <= (beats_q == 8'd0);
        rresp_q <= err_q ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_hs) begin
        rlast_q <= 1'b0;
        if (!rlast_q) begin
          beats_q <= beats_q - 8'd1;
          if (incr_q) addr_q <= next_idx;
        end
      end
    end
  end

  ram_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_clr  (rd_en && oob_q),
    .rd_addr (addr_q),
    .rd_data (s_axi.rdata)
  );

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_rd_slave_ram.sv
// Directed bench for axi_rd_slave_ram: bursts, backpressure, errors, collision, reset abort.
module tb_axi_rd_slave_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  int          errors = 0;
  int          checks = 0;

  axi_rd_if #(.ADDR_W(16), .DATA_W(32)) s_axi ();

  axi_rd_slave_ram #(.ADDR_W(16), .DATA_W(32), .DEPTH(256)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_axi   (s_axi),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one AR; returns at the negedge of the FETCH cycle.
  task automatic do_ar(input string tag, input logic [15:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    s_axi.araddr  = addr;
    s_axi.arlen   = len;
    s_axi.arburst = burst;
    s_axi.arsize  = 3'd2;
    s_axi.arvalid = 1'b1;
    for (int i = 0; i < 20 && !s_axi.arready; i++) @(negedge clk);
    check({tag, "_arready"}, 32'(s_axi.arready), 32'd1);
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    check({tag, "_ardrop"}, 32'(s_axi.arready), 32'd0);
    check({tag, "_fetch_rvalid"}, 32'(s_axi.rvalid), 32'd0);
  endtask

  task automatic get_beat(input string tag, input logic [31:0] d, input logic [1:0] r,
                          input logic l);
    for (int i = 0; i < 20 && !s_axi.rvalid; i++) @(negedge clk);
    check({tag, "_rvalid"}, 32'(s_axi.rvalid), 32'd1);
    check({tag, "_rdata"}, s_axi.rdata, d);
    check({tag, "_rresp"}, 32'(s_axi.rresp), 32'(r));
    check({tag, "_rlast"}, 32'(s_axi.rlast), 32'(l));
    @(negedge clk);
  endtask

  initial begin
    s_axi.araddr  = '0;
    s_axi.arlen   = '0;
    s_axi.arsize  = '0;
    s_axi.arburst = '0;
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b1;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    repeat (3) @(negedge clk);
    check("rst_arready", 32'(s_axi.arready), 32'd0);
    check("rst_rvalid", 32'(s_axi.rvalid), 32'd0);
    check("rst_rlast", 32'(s_axi.rlast), 32'd0);
    check("rst_rresp", 32'(s_axi.rresp), 32'd0);
    check("rst_rdata", s_axi.rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(i);
      ld_data = 32'h100 + 32'(i);
      @(negedge clk);
    end
    ld_en = 1'b0;

    // 1: INCR burst of four, latency two cycles from AR handshake.
    do_ar("t1", 16'h0000, 8'd3, 2'd1);
    @(negedge clk);
    check("t1_latency", 32'(s_axi.rvalid), 32'd1);
    get_beat("t1_b0", 32'h100, 2'd0, 1'b0);
    get_beat("t1_b1", 32'h101, 2'd0, 1'b0);
    get_beat("t1_b2", 32'h102, 2'd0, 1'b0);
    get_beat("t1_b3", 32'h103, 2'd0, 1'b1);
    check("t1_idle_arready", 32'(s_axi.arready), 32'd1);
    check("t1_idle_rvalid", 32'(s_axi.rvalid), 32'd0);

    // 2: FIXED burst repeats word 2.
    do_ar("t2", 16'h0008, 8'd2, 2'd0);
    get_beat("t2_b0", 32'h102, 2'd0, 1'b0);
    get_beat("t2_b1", 32'h102, 2'd0, 1'b0);
    get_beat("t2_b2", 32'h102, 2'd0, 1'b1);

    // 3: backpressure on beat 2, then a preload colliding with the beat-3 fetch.
    do_ar("t3", 16'h0010, 8'd2, 2'd1);
    get_beat("t3_b0", 32'h104, 2'd0, 1'b0);
    s_axi.rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_rvalid", 32'(s_axi.rvalid), 32'd1);
      check("t3_hold_rdata", s_axi.rdata, 32'h105);
    end
    s_axi.rready = 1'b1;
    get_beat("t3_b1", 32'h105, 2'd0, 1'b0);
    ld_en   = 1'b1;
    ld_addr = 8'd6;
    ld_data = 32'hABC;
    @(negedge clk);
    ld_en = 1'b0;
    get_beat("t3_b2_oldword", 32'h106, 2'd0, 1'b1);
    do_ar("t3r", 16'h0018, 8'd0, 2'd0);
    get_beat("t3r_newword", 32'hABC, 2'd0, 1'b1);

    // 4: start beyond DEPTH gives SLVERR with zero data; next burst recovers.
    do_ar("t4", 16'h0400, 8'd1, 2'd1);
    get_beat("t4_b0", 32'h0, 2'd2, 1'b0);
    get_beat("t4_b1", 32'h0, 2'd2, 1'b1);
    do_ar("t4n", 16'h0000, 8'd0, 2'd1);
    get_beat("t4n_b0", 32'h100, 2'd0, 1'b1);

    // 5: reserved burst type still returns data but flags SLVERR.
    do_ar("t5", 16'h0004, 8'd0, 2'd2);
    get_beat("t5_b0", 32'h101, 2'd2, 1'b1);

    // 6: reset during beat 2 of an eight-beat burst.
    do_ar("t6", 16'h0000, 8'd7, 2'd1);
    get_beat("t6_b0", 32'h100, 2'd0, 1'b0);
    s_axi.rready = 1'b0;
    for (int i = 0; i < 20 && !s_axi.rvalid; i++) @(negedge clk);
    check("t6_b1_rvalid", 32'(s_axi.rvalid), 32'd1);
    check("t6_b1_rdata", s_axi.rdata, 32'h101);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_rvalid", 32'(s_axi.rvalid), 32'd0);
    check("t6_rst_rlast", 32'(s_axi.rlast), 32'd0);
    rst = 1'b0;
    s_axi.rready = 1'b1;
    @(negedge clk);
    check("t6_post_arready", 32'(s_axi.arready), 32'd1);
    do_ar("t6n", 16'h001C, 8'd0, 2'd1);
    get_beat("t6n_b0", 32'h107, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
